// File: rtl/keypad_pkg.sv
// Shared helpers for the keypad scanner: event field layout,
// width helper and the elaboration-time parameter check.
`define KP_CHECK(label, cond) \
    if (!(cond)) begin : label \
        $error("keypad_scanner: illegal parameter value"); \
    end

package keypad_pkg;

    localparam int KEY_LSB = 0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int press_bit(input int key_w);
        return key_w + 1;
    endfunction

    function automatic int alt_bit(input int key_w);
        return key_w;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word fall-through event queue; a push into a full queue
// without a same-cycle pop is dropped and flagged for one cycle.
module key_event_fifo
    import keypad_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overflow_o
);

    localparam int AW = clog2(DEPTH);

    `KP_CHECK(g_chk_depth, DEPTH >= 2 && (DEPTH & (DEPTH - 1)) == 0)

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             empty, full, do_pop, do_push;

    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == (AW+1)'(DEPTH));
        do_pop  = pop_i && !empty;
        do_push = push_i && (!full || do_pop);
        ovf_d   = push_i && full && !do_pop;
        wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = do_pop ? rptr_q + AW'(1) : rptr_q;
        cnt_d   = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign valid_o    = !empty;
    assign data_o     = mem_q[rptr_q];
    assign overflow_o = ovf_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanned matrix keypad with per-key debounce, one-shot alt
// modifier and a press/release event queue.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 512,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int KEY_W     = clog2(ROWS * COLS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [ROWS-1:0]  rows,
    output logic [COLS-1:0]  columns,
    input  logic             alt_key,
    output logic             alt_led,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [KEY_W+1:0] ev_data,
    output logic             ev_overflow
);

    localparam int NK    = ROWS * COLS;
    localparam int EW    = KEY_W + 2;
    localparam int DVW   = clog2(SCAN_DIV);
    localparam int CW    = clog2(COLS);
    localparam int RW    = (ROWS > 1) ? clog2(ROWS) : 1;
    localparam int CNTW  = clog2(DEBOUNCE + 1);
    localparam int P_BIT = press_bit(KEY_W);
    localparam int A_BIT = alt_bit(KEY_W);

    `KP_CHECK(g_chk_rows, ROWS >= 1)
    `KP_CHECK(g_chk_cols, COLS >= 2)
    `KP_CHECK(g_chk_div, SCAN_DIV >= ROWS + 2)
    `KP_CHECK(g_chk_deb, DEBOUNCE >= 1)

    logic [ROWS-1:0] rows_s1_q, rows_s2_q;
    logic            alt_s1_q, alt_s2_q, alt_prev_q;
    logic [DVW-1:0]  div_q, div_d;
    logic [CW-1:0]   col_q, col_d, pcol_q, pcol_d;
    logic [ROWS-1:0] samp_q, samp_d;
    logic            primed_q, primed_d;
    logic            alt_armed_q, alt_armed_d;
    logic [NK-1:0]   stable_q;
    logic [CNTW-1:0] cnt_q [NK];

    logic            last, proc_en, samp_bit, differ, fire, alt_edge;
    logic [RW-1:0]   row;
    logic [KEY_W-1:0] key;
    logic [CNTW-1:0] cur_cnt;
    logic [EW-1:0]   push_data;
    int              key_int;

    always_comb begin
        last     = (div_q == DVW'(SCAN_DIV - 1));
        div_d    = div_q + DVW'(1);
        col_d    = col_q;
        pcol_d   = pcol_q;
        samp_d   = samp_q;
        primed_d = primed_q;
        if (last) begin
            div_d    = '0;
            col_d    = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
            pcol_d   = col_q;
            samp_d   = ~rows_s2_q;
            primed_d = 1'b1;
        end
    end

    // The first ROWS cycles of each dwell evaluate the previous column.
    always_comb begin
        proc_en  = primed_q && (div_q < DVW'(ROWS));
        row      = RW'(div_q);
        key_int  = int'(pcol_q) * ROWS + int'(row);
        key      = KEY_W'(key_int);
        samp_bit = samp_q[row];
        cur_cnt  = cnt_q[key];
        differ   = (samp_bit != stable_q[key]);
        fire     = proc_en && differ && (cur_cnt == CNTW'(DEBOUNCE - 1));
        alt_edge = alt_s2_q && !alt_prev_q;
        push_data = '0;
        push_data[P_BIT] = samp_bit;
        push_data[A_BIT] = alt_armed_q;
        push_data[KEY_LSB +: KEY_W] = key;
    end

    // A press consumes the modifier; that clear overrides a coincident edge.
    always_comb begin
        alt_armed_d = alt_armed_q;
        if (fire && samp_bit) alt_armed_d = 1'b0;
        else if (alt_edge)    alt_armed_d = !alt_armed_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rows_s1_q   <= '1;
            rows_s2_q   <= '1;
            alt_s1_q    <= 1'b0;
            alt_s2_q    <= 1'b0;
            alt_prev_q  <= 1'b0;
            div_q       <= '0;
            col_q       <= '0;
            pcol_q      <= '0;
            samp_q      <= '0;
            primed_q    <= 1'b0;
            alt_armed_q <= 1'b0;
        end else begin
            rows_s1_q   <= rows;
            rows_s2_q   <= rows_s1_q;
            alt_s1_q    <= alt_key;
            alt_s2_q    <= alt_s1_q;
            alt_prev_q  <= alt_s2_q;
            div_q       <= div_d;
            col_q       <= col_d;
            pcol_q      <= pcol_d;
            samp_q      <= samp_d;
            primed_q    <= primed_d;
            alt_armed_q <= alt_armed_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stable_q <= '0;
            for (int i = 0; i < NK; i++) cnt_q[i] <= '0;
        end else if (proc_en) begin
            if (!differ) begin
                cnt_q[key] <= '0;
            end else if (fire) begin
                stable_q[key] <= samp_bit;
                cnt_q[key]    <= '0;
            end else begin
                cnt_q[key] <= cur_cnt + CNTW'(1);
            end
        end
    end

    key_event_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clock),
        .rst_i      (reset),
        .push_i     (fire),
        .data_i     (push_data),
        .pop_i      (ev_ready),
        .data_o     (ev_data),
        .valid_o    (ev_valid),
        .overflow_o (ev_overflow)
    );

    assign columns = ~(COLS'(1) << col_q);
    assign alt_led = !alt_armed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a behavioural key matrix.
module tb_keypad_scanner;

    localparam int FRAME = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows;
    logic [3:0] columns;
    logic       alt_key = 1'b0;
    logic       alt_led;
    logic       ev_valid;
    logic       ev_ready = 1'b1;
    logic [5:0] ev_data;
    logic       ev_overflow;
    logic [15:0] pressed = '0;

    int checks = 0;
    int failures = 0;
    int vcount = 0;
    int ovf_cnt = 0;
    logic [5:0] sb [$];

    always #10 clk = ~clk;

    // A closed key pulls its row low while its column is driven.
    always_comb begin
        rows = '1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[c*4+r] && !columns[c]) rows[r] = 1'b0;
    end

    keypad_scanner #(
        .ROWS       (4),
        .COLS       (4),
        .SCAN_DIV   (16),
        .DEBOUNCE   (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clock       (clk),
        .reset       (reset),
        .rows        (rows),
        .columns     (columns),
        .alt_key     (alt_key),
        .alt_led     (alt_led),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_data     (ev_data),
        .ev_overflow (ev_overflow)
    );

    function automatic logic [5:0] ev(input bit p, input bit a, input int k);
        return {p, a, 4'(k)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_col0(output bit ok);
        logic [3:0] prev;
        prev = columns;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (columns == 4'b1110 && prev != 4'b1110) ok = 1'b1;
            prev = columns;
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [5:0] e;
        if (ev_valid) vcount++;
        if (ev_overflow) ovf_cnt++;
        if (!reset && ev_valid && ev_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL event: got %b expected none", ev_data);
            end else begin
                e = sb.pop_front();
                if (ev_data !== e) begin
                    failures++;
                    $display("FAIL event: got %b expected %b", ev_data, e);
                end
            end
        end
    end

    initial begin
        bit ok;
        int base;

        tick(3);
        reset = 1'b0;
        chk("rst_valid", ev_valid, 0);
        chk("rst_cols", columns, 4'b1110);
        chk("rst_led", alt_led, 1);
        chk("rst_ovf", ev_overflow, 0);

        sb.push_back(ev(1, 0, 9));
        pressed[9] = 1'b1;
        tick(6 * FRAME);
        sb.push_back(ev(0, 0, 9));
        pressed[9] = 1'b0;
        tick(5 * FRAME);
        chk("t1_drained", sb.size(), 0);

        base = vcount;
        pressed[0] = 1'b1;
        tick(2 * FRAME);
        pressed[0] = 1'b0;
        tick(4 * FRAME);
        chk("t2_no_event", vcount - base, 0);

        alt_key = 1'b1;
        tick(4);
        alt_key = 1'b0;
        tick(6);
        chk("t3_led_armed", alt_led, 0);
        sb.push_back(ev(1, 1, 15));
        pressed[15] = 1'b1;
        tick(5 * FRAME);
        chk("t3_led_cleared", alt_led, 1);
        sb.push_back(ev(0, 0, 15));
        pressed[15] = 1'b0;
        tick(5 * FRAME);
        chk("t3_drained", sb.size(), 0);

        wait_col0(ok);
        chk("t3_sync", ok, 1);
        pressed[15] = 1'b1;
        sb.push_back(ev(1, 0, 15));
        repeat (3) begin
            wait_col0(ok);
            chk("t3_sync", ok, 1);
        end
        @(negedge clk);
        alt_key = 1'b1;
        tick(4);
        alt_key = 1'b0;
        tick(10);
        chk("t3_clear_wins", alt_led, 1);
        chk("t3_coincide_ev", sb.size(), 0);
        sb.push_back(ev(0, 0, 15));
        pressed[15] = 1'b0;
        tick(5 * FRAME);
        chk("t3_rel_drained", sb.size(), 0);

        tick(1);
        ev_ready = 1'b0;
        base = ovf_cnt;
        wait_col0(ok);
        chk("t4_sync", ok, 1);
        pressed[4:0] = 5'h1f;
        for (int k = 0; k < 4; k++) sb.push_back(ev(1, 0, k));
        tick(5 * FRAME);
        chk("t4_ovf_pulses", ovf_cnt - base, 1);
        chk("t4_valid", ev_valid, 1);
        chk("t4_head", ev_data, ev(1, 0, 0));
        ev_ready = 1'b1;
        tick(3);
        chk("t4_one_per_cycle", sb.size(), 1);
        tick(1);
        chk("t4_drained", sb.size(), 0);
        chk("t4_empty", ev_valid, 0);
        wait_col0(ok);
        chk("t4_sync2", ok, 1);
        pressed[4:0] = 5'h00;
        for (int k = 0; k < 5; k++) sb.push_back(ev(0, 0, k));
        tick(5 * FRAME);
        chk("t4_rel_drained", sb.size(), 0);

        sb.push_back(ev(1, 0, 4));
        sb.push_back(ev(1, 0, 7));
        pressed[4] = 1'b1;
        pressed[7] = 1'b1;
        tick(5 * FRAME);
        chk("t5_press", sb.size(), 0);
        sb.push_back(ev(0, 0, 4));
        sb.push_back(ev(0, 0, 7));
        pressed[4] = 1'b0;
        pressed[7] = 1'b0;
        tick(5 * FRAME);
        chk("t5_release", sb.size(), 0);

        ev_ready = 1'b0;
        pressed[9] = 1'b1;
        pressed[10] = 1'b1;
        tick(5 * FRAME);
        chk("t6_queued", ev_valid, 1);
        alt_key = 1'b1;
        tick(4);
        alt_key = 1'b0;
        tick(6);
        chk("t6_led_armed", alt_led, 0);
        pressed[10] = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t6_valid", ev_valid, 0);
        chk("t6_cols", columns, 4'b1110);
        chk("t6_led", alt_led, 1);
        chk("t6_ovf", ev_overflow, 0);
        sb.delete();
        sb.push_back(ev(1, 0, 9));
        ev_ready = 1'b1;
        tick(5 * FRAME);
        chk("t6_repress", sb.size(), 0);
        sb.push_back(ev(0, 0, 9));
        pressed[9] = 1'b0;
        tick(5 * FRAME);
        chk("t6_release", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
